product_readout: RTL and testbench
==================================

Name: product_readout

Overview:
- Read-side counterpart to the operand load registers of the 4-bit signed sign-magnitude multiplier.
- Captures the finished product: the magnitude from the shift-add datapath plus the operand sign bits.
- Forms a signed product frame and streams it to the downstream consumer over a narrow valid/ready bus, LSB beat first.
- Holds the frame in a shadow register, so the datapath can start the next multiplication while readout is still in progress.

Parameters:
- MAG_W, default 4: operand magnitude width. Operands are MAG_W+1 bits, with the MSB as sign.
- OUT_W, default 4: width of one output beat.
- Derived, not overridable: PW = 2*MAG_W+1 (product frame bits). NBEATS = ceil(PW/OUT_W), which is 3 at defaults. FW = NBEATS*OUT_W (padded frame width).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_done  in  1  single-cycle pulse: product magnitude is valid this cycle
- i_sign_m  in  1  multiplicand sign bit (operand MSB)
- i_sign_q  in  1  multiplier sign bit (operand MSB)
- i_mag  in  2*MAG_W  unsigned product magnitude
- i_clr_ovr  in  1  clears o_overrun
- i_ready  in  1  downstream accepts the current beat
- o_valid  out  1  o_data holds a valid beat
- o_data  out  OUT_W  current beat
- o_last  out  1  current beat is beat NBEATS-1
- o_busy  out  1  a frame is held (state SEND)
- o_overrun  out  1  sticky: a product was dropped

Behaviour:
- Reset: i_rst_n=0 at a clock edge sets state=IDLE, beat counter=0, shadow=0, and all outputs to 0. This overrides everything, including mid-frame; the frame in flight is discarded and the beat is not completed.
- States:
  - IDLE: o_valid=0, o_busy=0.
  - SEND: o_valid=1, o_busy=1.
- IDLE -> SEND when i_done=1.
  - Frame is captured at that edge.
  - o_valid=1 with beat 0 in the following cycle. Latency from i_done to first beat is 1 cycle.
- Sign rule: sign = i_sign_m ^ i_sign_q, forced to 0 when i_mag == 0 (no negative zero).
- Frame format, sign-magnitude:
  - bits [2*MAG_W-1:0] = magnitude
  - bit 2*MAG_W = sign
  - bits [FW-1:PW] = 0
- Beat k drives frame bits [k*OUT_W +: OUT_W]. o_last=1 only when k = NBEATS-1.
- Handshake:
  - A beat transfers on a cycle where o_valid & i_ready.
  - While o_valid=1 and i_ready=0, o_data and o_last hold stable.
  - o_valid never drops before the last beat transfers.
- On transfer of the last beat:
  - Without a new i_done: SEND -> IDLE, and o_valid=0 the next cycle.
  - With i_done=1 in the same cycle: the new frame is captured, state stays SEND, and the counter returns to 0. Back-to-back frames run with no bubble.
- i_done=1 in SEND, other than on the last-beat transfer cycle:
  - The new product is dropped and the shadow is unchanged.
  - o_overrun is set the next cycle.
- o_overrun:
  - Cleared by i_clr_ovr or reset.
  - If i_clr_ovr and a set event occur in the same cycle, set wins.
- i_sign_m, i_sign_q and i_mag are sampled only on the capture edge. They are don't-care otherwise.

Optional Feature:
- Macro: PRODUCT_READOUT_TWOS_COMP_EN.
- Defined: the frame is the two's-complement value over FW bits.
  - Value is -mag when sign=1, else +mag, sign-extended through the pad bits.
  - The negative-zero rule still applies, so a zero product gives an all-zero frame.
  - Conversion is computed at capture, so beat timing is unchanged.
- Undefined: sign-magnitude frame as above.

Decomposition:
- Shared package multiplier_pkg holds:
  - MAG_W default and operand width MAG_W+1
  - PW, NBEATS and FW derivation, as a ceil-div function
  - state encoding constants IDLE/SEND
- Optional combinational sub-module product_frame_fmt: sign resolution plus the sign-magnitude/two's-complement packing. It is reused by the scoreboard model.
- The FSM, beat counter and overrun flag stay in product_readout.

Test Plan:
- Basic frame:
  - Stimulus: M=-3 (sign 1), Q=+5 (sign 0), i_mag=8'h0F pulse, i_ready=1.
  - Required: beats F,0,1 on consecutive cycles starting 1 cycle after i_done; o_last on beat 1; o_valid low next cycle.
  - With PRODUCT_READOUT_TWOS_COMP_EN defined: beats 1,F,F.
- Negative zero: sign_m=1, sign_q=0, i_mag=0 -> beats 0,0,0 in both macro settings.
- Backpressure: same frame as the basic case, i_ready=0 for the first 3 valid cycles -> o_data=F and o_last=0 held stable, then beats F,0,1 transfer.
- Back-to-back:
  - Stimulus: second i_done (+7 * +7, i_mag=8'h31) coincident with the last-beat transfer.
  - Required: next cycle shows beat 1, then 3, then 0; o_valid stays high throughout; o_overrun=0.
- Overrun and clear:
  - i_done during beat 0 of a frame -> dropped product never appears; o_overrun=1 next cycle.
  - i_clr_ovr pulse -> o_overrun=0.
- Reset mid-frame: i_rst_n=0 for 1 cycle during beat 1 -> o_valid, o_data, o_last, o_busy and o_overrun are all 0 the next cycle; a subsequent i_done produces a fresh beat 0.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared constants, frame-geometry helpers and FSM state encoding for the
// sign-magnitude multiplier and its product readout.
package multiplier_pkg;

  localparam int MAG_W_DEF = 4;
  localparam int OP_W_DEF  = MAG_W_DEF + 1;
  localparam int OUT_W_DEF = 4;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Product frame: 2*MAG_W magnitude bits plus one sign bit.
  function automatic int prod_w(input int mag_w);
    return 2 * mag_w + 1;
  endfunction

  function automatic int n_beats(input int mag_w, input int out_w);
    return ceil_div(prod_w(mag_w), out_w);
  endfunction

  function automatic int frame_w(input int mag_w, input int out_w);
    return n_beats(mag_w, out_w) * out_w;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/product_readout_if.sv
// Capture and beat-stream signals of the product readout block.
// slave is the readout block's view, master is the producer/consumer side.
interface product_readout_if #(
  parameter int MAG_W = 4,
  parameter int OUT_W = 4
);
  logic               done;
  logic               sign_m;
  logic               sign_q;
  logic [2*MAG_W-1:0] mag;
  logic               ready;
  logic               valid;
  logic [OUT_W-1:0]   data;
  logic               last;

  modport slave (
    input  done, sign_m, sign_q, mag, ready,
    output valid, data, last
  );

  modport master (
    output done, sign_m, sign_q, mag, ready,
    input  valid, data, last
  );
endinterface

// File: rtl/product_frame_fmt.sv
// Resolves the product sign and packs the padded product frame.
// PRODUCT_READOUT_TWOS_COMP_EN selects a two's-complement frame instead of sign-magnitude.
module product_frame_fmt
  import multiplier_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                                sign_m_i,
  input  logic                                sign_q_i,
  input  logic [2*MAG_W-1:0]                  mag_i,
  output logic [frame_w(MAG_W, OUT_W)-1:0]    frame_o
);
  localparam int FW = frame_w(MAG_W, OUT_W);

  logic sign;

  // A zero magnitude never carries a sign, so there is no negative zero.
  assign sign = (sign_m_i ^ sign_q_i) & (|mag_i);

`ifdef PRODUCT_READOUT_TWOS_COMP_EN
  logic [FW-1:0] mag_ext;

  assign mag_ext = FW'(mag_i);
  assign frame_o = sign ? (~mag_ext + 1'b1) : mag_ext;
`else
  assign frame_o = FW'({sign, mag_i});
`endif

endmodule

// File: rtl/product_readout.sv
// Captures a finished product into a shadow frame and streams it LSB beat
// first over a valid/ready bus. Optional macro: PRODUCT_READOUT_TWOS_COMP_EN.
module product_readout
  import multiplier_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  product_readout_if.slave   bus,
  input  logic               i_clr_ovr,
  output logic               o_busy,
  output logic               o_overrun
);
  localparam int NBEATS = n_beats(MAG_W, OUT_W);
  localparam int FW     = frame_w(MAG_W, OUT_W);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

  state_e                        state_q, state_d;
  logic [BW-1:0]                 beat_q, beat_d;
  logic [FW-1:0]                 shadow_q, shadow_d;
  logic                          ovr_q, ovr_d;
  logic [FW-1:0]                 frame;
  logic [NBEATS-1:0][OUT_W-1:0]  beats;
  logic                          is_last;
  logic                          xfer;
  logic                          ovr_set;

  product_frame_fmt #(
    .MAG_W (MAG_W),
    .OUT_W (OUT_W)
  ) u_fmt (
    .sign_m_i (bus.sign_m),
    .sign_q_i (bus.sign_q),
    .mag_i    (bus.mag),
    .frame_o  (frame)
  );

  assign beats   = shadow_q;
  assign is_last = (state_q == SEND) && (beat_q == LAST_BEAT);
  assign xfer    = (state_q == SEND) && bus.ready;

  assign bus.valid = (state_q == SEND);
  assign bus.data  = beats[beat_q];
  assign bus.last  = is_last;
  assign o_busy    = (state_q == SEND);
  assign o_overrun = ovr_q;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    beat_d   = beat_q;
    shadow_d = shadow_q;
    ovr_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.done) begin
          state_d  = SEND;
          beat_d   = '0;
          shadow_d = frame;
        end
      end
      SEND: begin
        if (xfer && is_last) begin
          // A product finishing on the last-beat transfer chains with no bubble.
          beat_d = '0;
          if (bus.done) shadow_d = frame;
          else          state_d  = IDLE;
        end else begin
          if (xfer)     beat_d  = beat_q + 1'b1;
          if (bus.done) ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Setting wins over a coincident clear.
    ovr_d = ovr_set | (ovr_q & ~i_clr_ovr);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: the shadow is a plain register and is cleared so o_data reads
      // zero after reset; no reset-free storage exists in this block.
      state_q  <= IDLE;
      beat_q   <= '0;
      shadow_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      shadow_q <= shadow_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: tb/tb_product_readout.sv
// Self-checking bench for product_readout at default widths (3 beats of 4 bits);
// expected beats are queued when a product is captured and checked on transfer.
module tb_product_readout;

  logic clk;
  logic rst_n;
  logic clr_ovr;
  logic busy;
  logic overrun;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    string      name;
    logic       sign_m;
    logic       sign_q;
    logic [7:0] mag;
    logic [11:0] exp_sm;
    logic [11:0] exp_tc;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tbl[7];

  product_readout_if #(.MAG_W(4), .OUT_W(4)) bus ();

  product_readout #(.MAG_W(4), .OUT_W(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus.slave),
    .i_clr_ovr (clr_ovr),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference for the frame the DUT should capture.
  function automatic logic [11:0] model_frame(input logic sm, input logic sq, input logic [7:0] mag);
    logic        s;
    logic [11:0] f;
    s = (sm ^ sq) && (mag != 8'h00);
`ifdef PRODUCT_READOUT_TWOS_COMP_EN
    f = {4'h0, mag};
    if (s) f = ~f + 12'd1;
`else
    f = {3'b000, s, mag};
`endif
    return f;
  endfunction

  task automatic push_frame(input logic [11:0] f);
    for (int k = 0; k < 3; k++) exp_q.push_back('{data: f[k*4 +: 4], last: (k == 2)});
  endtask

  // Pulse done for one cycle; returns in the cycle after the capture edge.
  task automatic pulse_done(input logic sm, input logic sq, input logic [7:0] mag);
    bus.done   = 1'b1;
    bus.sign_m = sm;
    bus.sign_q = sq;
    bus.mag    = mag;
    tick();
    bus.done   = 1'b0;
    bus.sign_m = 1'bx;
    bus.sign_q = 1'bx;
    bus.mag    = 8'hxx;
  endtask

  // Scoreboard: every transfer pops and compares the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus.valid && bus.ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data=%0h last=%0b, expected no beat", bus.data, bus.last);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 32'(bus.data), 32'(e.data));
        check("beat_last", 32'(bus.last), 32'(e.last));
      end
    end
  end

  initial begin
    logic [11:0] f;

    tbl[0] = '{"basic_m3_p5",  1'b1, 1'b0, 8'h0F, 12'h10F, 12'hFF1};
    tbl[1] = '{"neg_zero",     1'b1, 1'b0, 8'h00, 12'h000, 12'h000};
    tbl[2] = '{"p7_p7",        1'b0, 1'b0, 8'h31, 12'h031, 12'h031};
    tbl[3] = '{"m5_m5",        1'b1, 1'b1, 8'h19, 12'h019, 12'h019};
    tbl[4] = '{"p3_m7",        1'b0, 1'b1, 8'h15, 12'h115, 12'hFEB};
    tbl[5] = '{"max_neg",      1'b1, 1'b0, 8'hE1, 12'h1E1, 12'hF1F};
    tbl[6] = '{"max_pos",      1'b1, 1'b1, 8'hE1, 12'h0E1, 12'h0E1};

    rst_n      = 1'b0;
    clr_ovr    = 1'b0;
    bus.done   = 1'b0;
    bus.ready  = 1'b0;
    bus.sign_m = 1'b0;
    bus.sign_q = 1'b0;
    bus.mag    = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_valid",   32'(bus.valid), 32'd0);
    check("rst_data",    32'(bus.data),  32'd0);
    check("rst_last",    32'(bus.last),  32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);

    // Table vectors: single frames with the consumer always ready.
    bus.ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
`ifdef PRODUCT_READOUT_TWOS_COMP_EN
      f = tbl[i].exp_tc;
`else
      f = tbl[i].exp_sm;
`endif
      push_frame(f);
      pulse_done(tbl[i].sign_m, tbl[i].sign_q, tbl[i].mag);
      check({tbl[i].name, "_lat_valid"}, 32'(bus.valid), 32'd1);
      check({tbl[i].name, "_beat0_last"}, 32'(bus.last), 32'd0);
      tick();
      tick();
      check({tbl[i].name, "_beat2_last"}, 32'(bus.last), 32'd1);
      tick();
      check({tbl[i].name, "_end_valid"}, 32'(bus.valid), 32'd0);
      check({tbl[i].name, "_end_busy"},  32'(busy),      32'd0);
    end

    // Backpressure: first beat held stable for three stalled cycles.
    bus.ready = 1'b0;
    push_frame(model_frame(1'b1, 1'b0, 8'h0F));
    pulse_done(1'b1, 1'b0, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(bus.valid), 32'd1);
      check("bp_data",  32'(bus.data),  32'(model_frame(1'b1, 1'b0, 8'h0F) & 12'h00F));
      check("bp_last",  32'(bus.last),  32'd0);
      tick();
    end
    bus.ready = 1'b1;
    tick();
    tick();
    tick();
    check("bp_end_valid", 32'(bus.valid), 32'd0);

    // Back-to-back: second product captured on the last-beat transfer.
    push_frame(model_frame(1'b1, 1'b0, 8'h0F));
    pulse_done(1'b1, 1'b0, 8'h0F);
    tick();
    tick();
    check("b2b_on_last", 32'(bus.last), 32'd1);
    push_frame(model_frame(1'b0, 1'b0, 8'h31));
    pulse_done(1'b0, 1'b0, 8'h31);
    for (int i = 0; i < 3; i++) begin
      check("b2b_valid", 32'(bus.valid), 32'd1);
      tick();
    end
    check("b2b_end_valid", 32'(bus.valid), 32'd0);
    check("b2b_overrun",   32'(overrun),   32'd0);

    // Overrun: a product during beat 0 is dropped and flagged.
    push_frame(model_frame(0, 1, 8'h15));
    pulse_done(1'b0, 1'b1, 8'h15);
    pulse_done(1'b1, 1'b0, 8'hAA);
    check("ovr_set",        32'(overrun),  32'd1);
    check("ovr_still_busy", 32'(busy),     32'd1);
    tick();
    tick();
    check("ovr_end_valid",  32'(bus.valid), 32'd0);
    check("ovr_sticky",     32'(overrun),   32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared",    32'(overrun),   32'd0);

    // Set wins over a coincident clear.
    push_frame(model_frame(1, 1, 8'h19));
    pulse_done(1'b1, 1'b1, 8'h19);
    clr_ovr = 1'b1;
    pulse_done(1'b0, 1'b0, 8'h55);
    clr_ovr = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'd1);
    tick();
    tick();
    check("sw_end_valid", 32'(bus.valid), 32'd0);

    // Reset during beat 1 discards the frame and clears the sticky flag.
    push_frame(model_frame(1, 0, 8'hE1));
    pulse_done(1'b1, 1'b0, 8'hE1);
    tick();
    check("mid_beat1_valid", 32'(bus.valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("mid_rst_valid",   32'(bus.valid), 32'd0);
    check("mid_rst_data",    32'(bus.data),  32'd0);
    check("mid_rst_last",    32'(bus.last),  32'd0);
    check("mid_rst_busy",    32'(busy),      32'd0);
    check("mid_rst_overrun", 32'(overrun),   32'd0);

    push_frame(model_frame(0, 1, 8'h15));
    pulse_done(1'b0, 1'b1, 8'h15);
    check("fresh_valid", 32'(bus.valid), 32'd1);
    check("fresh_beat0", 32'(bus.data),  32'(model_frame(0, 1, 8'h15) & 12'h00F));
    tick();
    tick();
    tick();
    check("fresh_end_valid", 32'(bus.valid), 32'd0);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
